// File: rtl/prienc_arb.sv
// prienc_arb: registered N-input request arbiter with valid/ready grant hold.
// MODE=0 grants the highest set request index; MODE=1 rotates priority
// downward from the last accepted grant for round-robin fairness.
module prienc_arb #(
  parameter int N    = 4,
  parameter int MODE = 0,
  localparam int W   = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         gnt_ready,
  output logic         gnt_valid,
  output logic [W-1:0] gnt_idx,
  output logic [N-1:0] gnt_onehot,
  output logic         any_req
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t       state_q;
  logic [1:0]   rst_sync_q;
  logic         gnt_valid_q;
  logic [W-1:0] gnt_idx_q;
  logic [N-1:0] gnt_onehot_q;
  logic [W-1:0] last_q;

  logic         accept;
  logic [W-1:0] last_eff;
  logic [W-1:0] sel_d;
  logic [N-1:0] sel_onehot_d;

  // Highest set bit wins; returns 0 when nothing is set (never used then).
  function automatic logic [W-1:0] sel_fixed(input logic [N-1:0] r);
    logic [W-1:0] s;
    s = '0;
    for (int i = 0; i < N; i++) begin
      if (r[i]) s = W'(i);
    end
    return s;
  endfunction

  // Descending search starting just below the pointer, wrapping N-1 -> 0,
  // so the pointer's own index is the last candidate considered.
  function automatic logic [W-1:0] sel_rr(input logic [N-1:0] r,
                                          input logic [W-1:0] last);
    logic [W-1:0] s;
    logic         found;
    int           start;
    int           j;
    s     = '0;
    found = 1'b0;
    start = (last == '0) ? (N - 1) : (int'(last) - 1);
    for (int k = 0; k < N; k++) begin
      j = start - k;
      if (j < 0) j = j + N;
      if (!found && r[j]) begin
        s     = W'(j);
        found = 1'b1;
      end
    end
    return s;
  endfunction

  assign any_req = |req;
  assign accept  = gnt_valid_q & gnt_ready;

  // On an accept the pointer advances to the grant being retired in the same
  // edge, so a back-to-back grant must already search from that new position.
  assign last_eff     = accept ? gnt_idx_q : last_q;
  assign sel_d        = (MODE == 1) ? sel_rr(req, last_eff) : sel_fixed(req);
  assign sel_onehot_d = {{(N-1){1'b0}}, 1'b1} << sel_d;

  // Reset release synchroniser: assert is immediate, deassert after 2 edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  // Grant FSM: IDLE loads on any request, HOLD keeps the grant sticky until accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      gnt_valid_q  <= 1'b0;
      gnt_idx_q    <= '0;
      gnt_onehot_q <= '0;
      last_q       <= '0;
    end else if (!rst_sync_q[1]) begin
      state_q      <= IDLE;
      gnt_valid_q  <= 1'b0;
      gnt_idx_q    <= '0;
      gnt_onehot_q <= '0;
      last_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req) begin
            state_q      <= HOLD;
            gnt_valid_q  <= 1'b1;
            gnt_idx_q    <= sel_d;
            gnt_onehot_q <= sel_onehot_d;
          end
        end
        HOLD: begin
          if (gnt_ready) begin
            last_q <= gnt_idx_q;
            if (|req) begin
              gnt_idx_q    <= sel_d;
              gnt_onehot_q <= sel_onehot_d;
            end else begin
              state_q      <= IDLE;
              gnt_valid_q  <= 1'b0;
              gnt_onehot_q <= '0;
            end
          end
        end
        default: begin
          state_q      <= IDLE;
          gnt_valid_q  <= 1'b0;
          gnt_onehot_q <= '0;
        end
      endcase
    end
  end

  assign gnt_valid  = gnt_valid_q;
  assign gnt_idx    = gnt_idx_q;
  assign gnt_onehot = gnt_onehot_q;

endmodule

// File: tb/tb_prienc_arb.sv
// Testbench for prienc_arb: five instances covering fixed/round-robin modes
// at N=4, N=8 and N=2. Expected grants are queued by the stimulus and
// checked by per-instance monitors at every accepted grant.
module tb_prienc_arb;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] req0, req1, oh0, oh1;
  logic       rdy0, rdy1, v0, v1, any0, any1;
  logic [1:0] idx0, idx1;
  logic [7:0] req2, oh2;
  logic       rdy2, v2, any2;
  logic [2:0] idx2;
  logic [1:0] req3, oh3, req4, oh4;
  logic       rdy3, v3, any3, rdy4, v4, any4;
  logic       idx3, idx4;

  prienc_arb #(.N(4), .MODE(0)) u0 (.clk(clk), .rst_n(rst_n), .req(req0), .gnt_ready(rdy0),
    .gnt_valid(v0), .gnt_idx(idx0), .gnt_onehot(oh0), .any_req(any0));
  prienc_arb #(.N(4), .MODE(1)) u1 (.clk(clk), .rst_n(rst_n), .req(req1), .gnt_ready(rdy1),
    .gnt_valid(v1), .gnt_idx(idx1), .gnt_onehot(oh1), .any_req(any1));
  prienc_arb #(.N(8), .MODE(0)) u2 (.clk(clk), .rst_n(rst_n), .req(req2), .gnt_ready(rdy2),
    .gnt_valid(v2), .gnt_idx(idx2), .gnt_onehot(oh2), .any_req(any2));
  prienc_arb #(.N(2), .MODE(0)) u3 (.clk(clk), .rst_n(rst_n), .req(req3), .gnt_ready(rdy3),
    .gnt_valid(v3), .gnt_idx(idx3), .gnt_onehot(oh3), .any_req(any3));
  prienc_arb #(.N(2), .MODE(1)) u4 (.clk(clk), .rst_n(rst_n), .req(req4), .gnt_ready(rdy4),
    .gnt_valid(v4), .gnt_idx(idx4), .gnt_onehot(oh4), .any_req(any4));

  int n_cmp = 0;
  int n_err = 0;
  int q0[$], q1[$], q2[$], q3[$], q4[$];

  // Legacy 4-input encoder truth table; -1 means no grant.
  int exp_tab[16] = '{-1, 0, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3, 3, 3, 3, 3};

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    end
  endtask

  task automatic unexp(input string nm, input int act);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got grant %0d, required no grant", nm, act);
  endtask

  function automatic int ohx(input logic v, input int idx);
    return v ? (1 << idx) : 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitors: onehot consistency every cycle, grant index on every accept.
  always @(negedge clk) begin
    chk("oh0", int'(oh0), ohx(v0, int'(idx0)));
    if (v0 && rdy0) begin
      if (q0.size() == 0) unexp("gnt0", int'(idx0));
      else chk("gnt0", int'(idx0), q0.pop_front());
    end
  end
  always @(negedge clk) begin
    chk("oh1", int'(oh1), ohx(v1, int'(idx1)));
    if (v1 && rdy1) begin
      if (q1.size() == 0) unexp("gnt1", int'(idx1));
      else chk("gnt1", int'(idx1), q1.pop_front());
    end
  end
  always @(negedge clk) begin
    chk("oh2", int'(oh2), ohx(v2, int'(idx2)));
    if (v2 && rdy2) begin
      if (q2.size() == 0) unexp("gnt2", int'(idx2));
      else chk("gnt2", int'(idx2), q2.pop_front());
    end
  end
  always @(negedge clk) begin
    chk("oh3", int'(oh3), ohx(v3, int'(idx3)));
    if (v3 && rdy3) begin
      if (q3.size() == 0) unexp("gnt3", int'(idx3));
      else chk("gnt3", int'(idx3), q3.pop_front());
    end
  end
  always @(negedge clk) begin
    chk("oh4", int'(oh4), ohx(v4, int'(idx4)));
    if (v4 && rdy4) begin
      if (q4.size() == 0) unexp("gnt4", int'(idx4));
      else chk("gnt4", int'(idx4), q4.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    req0 = '0; req1 = '0; req2 = '0; req3 = '0; req4 = '0;
    rdy0 = 1'b1; rdy1 = 1'b1; rdy2 = 1'b1; rdy3 = 1'b1; rdy4 = 1'b1;

    // Reset state
    #12;
    chk("rst_valid0", int'(v0), 0);
    chk("rst_idx0", int'(idx0), 0);
    chk("rst_oh0", int'(oh0), 0);
    chk("rst_valid1", int'(v1), 0);
    rst_n = 1'b1;
    repeat (4) tick();

    // Exhaustive sweep, N=4 fixed priority
    for (int v = 0; v < 16; v++) begin
      req0 = 4'(v);
      if (exp_tab[v] >= 0) begin
        q0.push_back(exp_tab[v]);
        q0.push_back(exp_tab[v]);
      end
      #1;
      chk("any_req0", int'(any0), (v != 0) ? 1 : 0);
      tick();
      tick();
      if (v == 0) chk("sweep_idle_valid", int'(v0), 0);
    end
    req0 = '0;
    tick();
    tick();
    chk("sweep_end_valid", int'(v0), 0);

    // Sticky hold
    rdy0 = 1'b0;
    req0 = 4'b0110;
    tick();
    chk("hold_valid", int'(v0), 1);
    chk("hold_idx", int'(idx0), 2);
    chk("hold_oh", int'(oh0), 4);
    req0 = 4'b1001;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("sticky_idx", int'(idx0), 2);
    end
    q0.push_back(2);
    rdy0 = 1'b1;
    tick();
    rdy0 = 1'b0;
    chk("after_accept_idx", int'(idx0), 3);
    chk("after_accept_valid", int'(v0), 1);
    q0.push_back(3);
    rdy0 = 1'b1;
    req0 = '0;
    tick();
    tick();
    chk("hold_end_valid", int'(v0), 0);

    // Round-robin fairness, all requesting
    req1 = 4'b1111;
    for (int r = 0; r < 2; r++) begin
      q1.push_back(3); q1.push_back(2); q1.push_back(1); q1.push_back(0);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("rr_no_bubble", int'(v1), 1);
      chk("any_req1", int'(any1), 1);
    end
    req1 = '0;
    tick();
    tick();
    chk("rr_end_valid", int'(v1), 0);

    // Round-robin skip and wrap
    req1 = 4'b0010;
    q1.push_back(1);
    tick();
    req1 = 4'b0011;
    q1.push_back(0);
    q1.push_back(1);
    tick();
    tick();
    req1 = '0;
    tick();
    tick();
    chk("skip_end_valid", int'(v1), 0);

    // Width generalisation
    req2 = 8'b0100_0001;
    q2.push_back(6);
    req3 = 2'b11;
    q3.push_back(1);
    req4 = 2'b11;
    q4.push_back(1); q4.push_back(0); q4.push_back(1);
    #1;
    chk("any_req2", int'(any2), 1);
    chk("any_req3", int'(any3), 1);
    chk("any_req4", int'(any4), 1);
    tick();
    req2 = '0;
    req3 = '0;
    tick();
    tick();
    req4 = '0;
    tick();
    tick();
    chk("w8_end_valid", int'(v2), 0);
    chk("w2_end_valid", int'(v4), 0);

    // Reset mid-HOLD with a non-zero pointer (last=1 from the skip test)
    rdy1 = 1'b0;
    req1 = 4'b1000;
    tick();
    chk("pre_rst_idx", int'(idx1), 3);
    chk("pre_rst_valid", int'(v1), 1);
    rst_n = 1'b0;
    req1 = 4'b1111;
    #2;
    chk("rst_mid_valid", int'(v1), 0);
    chk("rst_mid_oh", int'(oh1), 0);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 10 && !v1; i++) tick();
    chk("rst_regrant_valid", int'(v1), 1);
    if (v1) begin
      q1.push_back(3);
      rdy1 = 1'b1;
      req1 = '0;
      tick();
      tick();
      chk("rst_end_valid", int'(v1), 0);
    end

    chk("q0_left", q0.size(), 0);
    chk("q1_left", q1.size(), 0);
    chk("q2_left", q2.size(), 0);
    chk("q3_left", q3.size(), 0);
    chk("q4_left", q4.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
